// File: rtl/que_axis_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : que_axis_pkg                                               |
// | Brief   : Shared types and constants for the queue-to-AXIS reader.   |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package que_axis_pkg;

  // Output buffer depth; also the pop credit limit (occupancy + in-flight).
  localparam int OBUF_DEPTH = 3;

  // Default data width for the packed beat type below.
  localparam int DEF_WD = 32;

  // Occupancy of the output buffer, 0..OBUF_DEPTH.
  typedef logic [1:0] occ_t;

  // One buffered stream beat: framing flag plus payload.
  typedef struct packed {
    logic              last;
    logic [DEF_WD-1:0] data;
  } beat_t;

endpackage : que_axis_pkg
`default_nettype wire

// File: rtl/axis_obuf.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : axis_obuf                                                  |
// | Brief   : Small shift-register FIFO. Entry 0 is the head and drives  |
// |           the stream outputs straight from flops.                    |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module axis_obuf
  import que_axis_pkg::*;
#(
  parameter int WD = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        wr,
  input  logic [WD:0] wdata,
  input  logic        rd,
  output logic [WD:0] rdata,
  output occ_t        occ
);

  logic [WD:0] r_mem [OBUF_DEPTH];
  occ_t        r_occ;
  logic        w_rd_ok;
  occ_t        w_widx;

  // A read only pops when something is present; the write slot moves down
  // by one when a read shifts the array in the same cycle.
  always_comb begin
    w_rd_ok = rd & (r_occ != '0);
    w_widx  = w_rd_ok ? (r_occ - occ_t'(1)) : r_occ;
  end

  // Storage: shift toward the head on read, then drop the new word in the
  // first free slot (the later assignment wins when both hit one slot).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < OBUF_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      for (int i = 0; i < OBUF_DEPTH; i++) begin
        if (w_rd_ok && (i < OBUF_DEPTH - 1)) begin
          r_mem[i] <= r_mem[i+1];
        end
        if (wr && !clr && (w_widx == occ_t'(i))) begin
          r_mem[i] <= wdata;
        end
      end
    end
  end

  // Occupancy: clear wins; a simultaneous write and read leave it unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_occ <= '0;
    end else if (clr) begin
      r_occ <= '0;
    end else begin
      r_occ <= r_occ + occ_t'(wr) - occ_t'(w_rd_ok);
    end
  end

  assign rdata = r_mem[0];
  assign occ   = r_occ;

endmodule : axis_obuf
`default_nettype wire

// File: rtl/que_axis_reader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : que_axis_reader                                            |
// | Brief   : Drains a registered-read push/pop FIFO into an AXI4-Stream |
// |           master with backpressure and length-based TLAST framing.   |
// |           Pops are credit based so tready never reaches que_pop.     |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module que_axis_reader
  import que_axis_pkg::*;
#(
  parameter int WD    = 32,
  parameter int LENW  = 16,
  parameter int PCNTW = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             flush,
  input  logic [LENW-1:0]  pkt_len,
  input  logic [WD-1:0]    que_dout,
  input  logic             que_empty,
  output logic             que_pop,
  output logic [WD-1:0]    m_axis_tdata,
  output logic             m_axis_tvalid,
  output logic             m_axis_tlast,
  input  logic             m_axis_tready,
  output logic [PCNTW-1:0] pkt_cnt,
  output logic             busy
);

  logic             r_run;
  logic             r_inflight;
  logic [LENW-1:0]  r_beat_idx;
  logic [LENW-1:0]  r_len_q;
  logic [PCNTW-1:0] r_pkt_cnt;

  occ_t             w_occ;
  logic [WD:0]      w_head;
  logic [WD:0]      w_wdata;
  logic [2:0]       w_used;
  logic             w_wr;
  logic             w_fire;
  logic [LENW-1:0]  w_len_eff;
  logic             w_last;

  // Pop credit: buffered words plus the one still coming out of the FIFO
  // must leave room, so a pop never depends on the downstream ready.
  always_comb begin
    w_used  = {1'b0, w_occ} + {2'b00, r_inflight};
    que_pop = r_run & en & ~flush & ~que_empty & (w_used < 3'(OBUF_DEPTH));
  end

  // Framing: the packet length is sampled with the first word of a packet
  // and held until its last word, so mid-packet pkt_len edits wait a packet.
  always_comb begin
    w_wr      = r_inflight & ~flush;
    w_fire    = m_axis_tvalid & m_axis_tready;
    w_len_eff = (r_beat_idx == '0) ? pkt_len : r_len_q;
    w_last    = (w_len_eff != '0) & (r_beat_idx == (w_len_eff - LENW'(1)));
    w_wdata   = {w_last, que_dout};
  end

  // Run flag: holds off popping until the first clock after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run <= 1'b0;
    end else begin
      r_run <= 1'b1;
    end
  end

  // In-flight marker: the popped word appears on que_dout one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= que_pop;
    end
  end

  // Beat index and latched length; flush restarts the packet from beat 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_beat_idx <= '0;
      r_len_q    <= '0;
    end else if (flush) begin
      r_beat_idx <= '0;
      r_len_q    <= pkt_len;
    end else if (w_wr) begin
      r_len_q    <= w_len_eff;
      r_beat_idx <= w_last ? '0 : (r_beat_idx + LENW'(1));
    end
  end

  // Completed packets; a last beat accepted during a flush still counts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pkt_cnt <= '0;
    end else if (w_fire && m_axis_tlast) begin
      r_pkt_cnt <= r_pkt_cnt + PCNTW'(1);
    end
  end

  axis_obuf #(
    .WD (WD)
  ) u_obuf (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush),
    .wr    (w_wr),
    .wdata (w_wdata),
    .rd    (w_fire),
    .rdata (w_head),
    .occ   (w_occ)
  );

  assign m_axis_tvalid = (w_occ != '0);
  assign m_axis_tdata  = w_head[WD-1:0];
  assign m_axis_tlast  = w_head[WD];
  assign pkt_cnt       = r_pkt_cnt;
  assign busy          = (w_occ != '0) | r_inflight;

endmodule : que_axis_reader
`default_nettype wire

// File: tb/tb_que_axis_reader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_que_axis_reader                                         |
// | Brief   : Directed self-checking bench for que_axis_reader with a    |
// |           behavioural registered-read FIFO on the pop side.          |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tb_que_axis_reader;

  localparam int WD    = 32;
  localparam int LENW  = 16;
  localparam int PCNTW = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en;
  logic             flush;
  logic [LENW-1:0]  pkt_len;
  logic [WD-1:0]    que_dout = '0;
  logic             que_empty;
  logic             que_pop;
  logic [WD-1:0]    m_axis_tdata;
  logic             m_axis_tvalid;
  logic             m_axis_tlast;
  logic             m_axis_tready;
  logic [PCNTW-1:0] pkt_cnt;
  logic             busy;

  int checks = 0;
  int errors = 0;

  que_axis_reader #(.WD(WD), .LENW(LENW), .PCNTW(PCNTW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .en            (en),
    .flush         (flush),
    .pkt_len       (pkt_len),
    .que_dout      (que_dout),
    .que_empty     (que_empty),
    .que_pop       (que_pop),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready),
    .pkt_cnt       (pkt_cnt),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  // Behavioural FIFO: bench writes via wr_ptr, model reads via rd_ptr.
  logic [WD-1:0] q_mem [0:255];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign que_empty = (wr_ptr == rd_ptr);

  // Stream capture and pop bookkeeping.
  int cyc = 0;
  int pop_n = 0;
  int pop_empty_n = 0;
  int rx_n = 0;
  logic [WD-1:0] rx_data [0:255];
  logic          rx_last [0:255];
  int            rx_cyc  [0:255];

  // FIFO read port and stream monitor.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (que_pop) begin
      pop_n <= pop_n + 1;
      if (que_empty) pop_empty_n <= pop_empty_n + 1;
      que_dout <= q_mem[rd_ptr[7:0]];
      rd_ptr   <= rd_ptr + 1;
    end
    if (m_axis_tvalid && m_axis_tready) begin
      rx_data[rx_n[7:0]] <= m_axis_tdata;
      rx_last[rx_n[7:0]] <= m_axis_tlast;
      rx_cyc[rx_n[7:0]]  <= cyc;
      rx_n <= rx_n + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [WD-1:0] v);
    q_mem[wr_ptr[7:0]] = v;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic wait_rx(input int target);
    int k = 0;
    while (rx_n < target && k < 300) begin
      tick();
      k++;
    end
    checks++;
    if (rx_n < target) begin
      errors++;
      $display("FAIL wait_rx: got %0d beats, need %0d", rx_n, target);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; flush = 1'b0; pkt_len = 16'd4; m_axis_tready = 1'b1;
    for (int i = 1; i <= 8; i++) push(WD'(i));
    tick(); tick(); tick();
    checks++;
    if ({que_pop, m_axis_tvalid, m_axis_tlast, busy} !== 4'b0000 || m_axis_tdata !== '0 || pkt_cnt !== '0) begin
      errors++;
      $display("FAIL reset_state: pop=%b tvalid=%b tlast=%b busy=%b tdata=%h pkt_cnt=%0d, need all 0",
               que_pop, m_axis_tvalid, m_axis_tlast, busy, m_axis_tdata, pkt_cnt);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (que_pop !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_pop: que_pop=%b, need 1", que_pop);
    end
  endtask

  task automatic test_streaming();
    int bad = 0;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (que_pop !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL stream_pop_run: %0d gaps in pop run, need 0", bad);
    end
    tick();
    checks++;
    if (que_pop !== 1'b0) begin
      errors++;
      $display("FAIL stream_pop_empty: que_pop=%b, need 0", que_pop);
    end
    wait_rx(8);
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      if (rx_data[i] !== WD'(i + 1) || rx_last[i] !== (i == 3 || i == 7)) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL stream_data: %0d bad beats, need 0", bad);
    end
    checks++;
    if (rx_cyc[7] - rx_cyc[0] != 7) begin
      errors++;
      $display("FAIL stream_b2b: span %0d cycles, need 7", rx_cyc[7] - rx_cyc[0]);
    end
    checks++;
    if (pkt_cnt !== 16'd2 || pop_n != 8) begin
      errors++;
      $display("FAIL stream_counts: pkt_cnt=%0d pops=%0d, need 2 and 8", pkt_cnt, pop_n);
    end
  endtask

  task automatic test_backpressure();
    int base_pop;
    int base_rx;
    int bad = 0;
    base_pop = pop_n;
    base_rx  = rx_n;
    m_axis_tready = 1'b0;
    for (int i = 0; i < 8; i++) push(32'h11 + WD'(i));
    for (int i = 0; i < 4; i++) tick();
    for (int i = 0; i < 10; i++) begin
      tick();
      if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'h11 || m_axis_tlast !== 1'b0 || que_pop !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL bp_hold: %0d unstable cycles, need 0", bad);
    end
    checks++;
    if (pop_n - base_pop != 3 || dut.w_occ !== 2'd3) begin
      errors++;
      $display("FAIL bp_credit: pops=%0d occ=%0d, need 3 and 3", pop_n - base_pop, dut.w_occ);
    end
    m_axis_tready = 1'b1;
    wait_rx(base_rx + 8);
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      if (rx_data[base_rx + i] !== 32'h11 + WD'(i) || rx_last[base_rx + i] !== (i == 3 || i == 7)) bad++;
    end
    checks++;
    if (bad != 0 || pkt_cnt !== 16'd4) begin
      errors++;
      $display("FAIL bp_data: %0d bad beats pkt_cnt=%0d, need 0 and 4", bad, pkt_cnt);
    end
  endtask

  task automatic test_pkt_len();
    int base_rx;
    int bad = 0;
    base_rx = rx_n;
    pkt_len = 16'd0;
    for (int i = 0; i < 20; i++) push(32'h100 + WD'(i));
    wait_rx(base_rx + 20);
    for (int i = 0; i < 20; i++) begin
      if (rx_data[base_rx + i] !== 32'h100 + WD'(i) || rx_last[base_rx + i] !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0 || pkt_cnt !== 16'd4) begin
      errors++;
      $display("FAIL len0: %0d bad beats pkt_cnt=%0d, need 0 and 4", bad, pkt_cnt);
    end
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    base_rx = rx_n;
    pkt_len = 16'd3;
    push(32'h200);
    wait_rx(base_rx + 1);
    pkt_len = 16'd5;
    for (int i = 1; i < 8; i++) push(32'h200 + WD'(i));
    wait_rx(base_rx + 8);
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      if (rx_data[base_rx + i] !== 32'h200 + WD'(i) || rx_last[base_rx + i] !== (i == 2 || i == 7)) bad++;
    end
    checks++;
    if (bad != 0 || pkt_cnt !== 16'd6) begin
      errors++;
      $display("FAIL len_change: %0d bad beats pkt_cnt=%0d, need 0 and 6", bad, pkt_cnt);
    end
  endtask

  task automatic test_flush();
    int base_rx;
    int k = 0;
    int bad = 0;
    pkt_len = 16'd4;
    m_axis_tready = 1'b0;
    for (int i = 0; i < 5; i++) push(32'h300 + WD'(i));
    while (!(dut.w_occ == 2'd2 && dut.r_inflight == 1'b1) && k < 20) begin
      tick();
      k++;
    end
    checks++;
    if (!(dut.w_occ == 2'd2 && dut.r_inflight == 1'b1)) begin
      errors++;
      $display("FAIL flush_setup: occ=%0d inflight=%b, need 2 and 1", dut.w_occ, dut.r_inflight);
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++;
    if (m_axis_tvalid !== 1'b0 || dut.w_occ !== 2'd0 || busy !== 1'b0 || pkt_cnt !== 16'd6) begin
      errors++;
      $display("FAIL flush_clear: tvalid=%b occ=%0d busy=%b pkt_cnt=%0d, need 0 0 0 6",
               m_axis_tvalid, dut.w_occ, busy, pkt_cnt);
    end
    base_rx = rx_n;
    m_axis_tready = 1'b1;
    push(32'h305);
    push(32'h306);
    wait_rx(base_rx + 4);
    for (int i = 0; i < 4; i++) begin
      if (rx_data[base_rx + i] !== 32'h303 + WD'(i) || rx_last[base_rx + i] !== (i == 3)) bad++;
    end
    checks++;
    if (bad != 0 || pkt_cnt !== 16'd7) begin
      errors++;
      $display("FAIL flush_restart: %0d bad beats pkt_cnt=%0d, need 0 and 7", bad, pkt_cnt);
    end
  endtask

  task automatic test_enable();
    int base_rx;
    int base_pop;
    int k = 0;
    int pop_bad = 0;
    int bad = 0;
    base_rx = rx_n;
    m_axis_tready = 1'b0;
    for (int i = 0; i < 4; i++) push(32'h400 + WD'(i));
    for (int i = 0; i < 5; i++) tick();
    en = 1'b0;
    m_axis_tready = 1'b1;
    base_pop = pop_n;
    while (rx_n < base_rx + 3 && k < 20) begin
      tick();
      k++;
      if (que_pop !== 1'b0) pop_bad++;
    end
    checks++;
    if (pop_bad != 0 || pop_n != base_pop || rx_n != base_rx + 3) begin
      errors++;
      $display("FAIL en_nopop: pop_cycles=%0d pops=%0d beats=%0d, need 0 0 3",
               pop_bad, pop_n - base_pop, rx_n - base_rx);
    end
    checks++;
    if (busy !== 1'b0 || m_axis_tvalid !== 1'b0 || que_empty !== 1'b0) begin
      errors++;
      $display("FAIL en_idle: busy=%b tvalid=%b que_empty=%b, need 0 0 0", busy, m_axis_tvalid, que_empty);
    end
    for (int i = 0; i < 3; i++) begin
      if (rx_data[base_rx + i] !== 32'h400 + WD'(i) || rx_last[base_rx + i] !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL en_drain: %0d bad beats, need 0", bad);
    end
    en = 1'b1;
    wait_rx(base_rx + 4);
    checks++;
    if (rx_data[base_rx + 3] !== 32'h403 || rx_last[base_rx + 3] !== 1'b1 || pkt_cnt !== 16'd8) begin
      errors++;
      $display("FAIL en_resume: data=%h last=%b pkt_cnt=%0d, need 403 1 8",
               rx_data[base_rx + 3], rx_last[base_rx + 3], pkt_cnt);
    end
    checks++;
    if (pop_empty_n != 0) begin
      errors++;
      $display("FAIL pop_when_empty: %0d pops, need 0", pop_empty_n);
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_pkt_len();
    test_flush();
    test_enable();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_que_axis_reader
`default_nettype wire
